// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
//
// Multi-stage pipeline register. STAGES ranks of WIDTH-bit data, and each rank
// carries a valid bit. A global stall freezes every rank. A flush or reset
// empties the chain. When valid_in is low, a clean bubble (RESET_VAL) enters
// stage 0. Occupancy and empty are kept in registers next to the chain, so
// they need no popcount on the output path.
//
// Optional build macro: PIPE_REG_CHAIN_PARITY_EN
//   When defined, each rank also stores an even-parity bit of its data. The
//   extra output parity_err flags a corrupted entry as it lands in the last
//   rank.
//
// Parameters:
//   WIDTH      data width per stage (>= 1)
//   STAGES     number of register ranks, equal to the latency in cycles (>= 1)
//   RESET_VAL  data loaded on reset, on flush, and for bubbles
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   d          data into stage 0
//   valid_in   d is a real entry this cycle
//   stall      hold all stages
//   flush      invalidate all stages (overrides stall)
//   q          data of the last stage
//   valid_out  valid bit of the last stage
//   occupancy  number of stages that hold valid entries
//   empty      occupancy == 0
//   parity_err (parity build only) last-stage entry failed its parity check
// -----------------------------------------------------------------------------
module pipe_reg_chain #(
  parameter int              WIDTH     = 64,
  parameter int              STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            d,
  input  logic                        valid_in,
  input  logic                        stall,
  input  logic                        flush,
  output logic [WIDTH-1:0]            q,
  output logic                        valid_out,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic                        empty
`ifdef PIPE_REG_CHAIN_PARITY_EN
  ,
  output logic                        parity_err
`endif
);

  localparam int CW = $clog2(STAGES + 1);

  if (STAGES < 1) begin : g_bad_stages
    $error("pipe_reg_chain: STAGES must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_reg_chain: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] data_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0] stage0_d;
  logic [CW-1:0]    occ_next;
  logic             kill;

  // Reset and flush have the same effect on the chain, so one term covers
  // both and reset still takes priority over everything else.
  assign kill = reset | flush;

  // A bubble carries RESET_VAL and never d, so an invalid slot holds no stale
  // or X data.
  assign stage0_d = valid_in ? d : RESET_VAL;

  // NOTE: every always_ff uses only non-blocking assignments. Each rank then
  // samples the old value of its neighbour, and the shift behaves as a true
  // register chain.
  always_ff @(posedge clk) begin
    if (kill) begin
      // NOTE: the data array is reset as well as the valid bits. Downstream
      // logic may read q without checking valid_out, so q must never carry X.
      for (int k = 0; k < STAGES; k++) data_q[k] <= RESET_VAL;
      valid_q <= '0;
    end else if (!stall) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
      data_q[0]  <= stage0_d;
      valid_q[0] <= valid_in;
    end
  end

  // q and valid_out come straight from the last-rank flops.
  assign q         = data_q[STAGES-1];
  assign valid_out = valid_q[STAGES-1];

  // One entry may enter while the last one leaves. A full chain always has a
  // valid last rank, so the count stays within 0..STAGES.
  // NOTE: occ_next gets a default before the conditional update. Every path
  // then assigns it, and no latch is inferred.
  always_comb begin
    occ_next = occupancy;
    if (!stall) begin
      occ_next = occupancy + CW'(valid_in) - CW'(valid_q[STAGES-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      occupancy <= '0;
      empty     <= 1'b1;
    end else begin
      occupancy <= occ_next;
      empty     <= (occ_next == '0);
    end
  end

  occ_matches_popcount: assert property (
    @(posedge clk) disable iff (reset)
      32'(occupancy) == $countones(valid_q)
  );

`ifdef PIPE_REG_CHAIN_PARITY_EN
  logic [STAGES-1:0] par_q;
  logic [WIDTH-1:0]  last_in_data;
  logic              last_in_par;
  logic              last_in_valid;

  // The check runs on the entry about to load into the last rank. The flag
  // therefore lines up with the cycle in which that entry shows on q.
  if (STAGES == 1) begin : g_last_in_input
    always_comb begin
      last_in_data  = stage0_d;
      last_in_par   = ^stage0_d;
      last_in_valid = valid_in;
    end
  end else begin : g_last_in_chain
    always_comb begin
      last_in_data  = data_q[STAGES-2];
      last_in_par   = par_q[STAGES-2];
      last_in_valid = valid_q[STAGES-2];
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      par_q      <= {STAGES{^RESET_VAL}};
      parity_err <= 1'b0;
    end else if (!stall) begin
      for (int k = STAGES - 1; k > 0; k--) par_q[k] <= par_q[k-1];
      par_q[0]   <= ^stage0_d;
      parity_err <= last_in_valid & ((^last_in_data) != last_in_par);
    end
  end
`endif

endmodule
